// File: rtl/rx_scrambler_pkg.sv
// rtl/rx_scrambler_pkg.sv - shared states and constants for the 802.11a receive descrambler
package rx_scrambler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SERVICE,
    ST_PSDU,
    ST_TAIL,
    ST_PAD
  } state_e;

  localparam int SEED_LEN    = 7;
  localparam int SERVICE_LEN = 16;
  localparam int TAIL_LEN    = 6;
  localparam int LFSR_TAP_HI = 6;
  localparam int LFSR_TAP_LO = 3;
  localparam int NDBPS_MIN   = 24;

endpackage

// File: rtl/descrambler_lfsr.sv
// rtl/descrambler_lfsr.sv - x^7+x^4+1 seed capture and keystream register
module descrambler_lfsr
  import rx_scrambler_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic step_i,
  input  logic bit_i,
  output logic key_o
);

  logic [SEED_LEN-1:0] s_q, s_d;

  assign key_o = s_q[LFSR_TAP_HI] ^ s_q[LFSR_TAP_LO];

  // Seed bits are received scrambled-zero, i.e. raw keystream, so they shift in directly.
  always_comb begin
    s_d = s_q;
    if (load_i) begin
      s_d = {s_q[SEED_LEN-2:0], bit_i};
    end else if (step_i) begin
      s_d = {s_q[SEED_LEN-2:0], key_o};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/descrambler_frame_ctrl.sv
// rtl/descrambler_frame_ctrl.sv - DATA-field sequencer: seed recovery, SERVICE check, PSDU forward, tail/pad drop
module descrambler_frame_ctrl
  import rx_scrambler_pkg::*;
#(
  parameter int LEN_W   = 12,
  parameter int NDBPS_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   length_i,
  input  logic [NDBPS_W-1:0] ndbps_i,
  input  logic               in_valid_i,
  input  logic               in_bit_i,
  output logic               out_valid_o,
  output logic               out_bit_o,
  output logic               out_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               service_err_o,
  output logic               rate_err_o
);

  localparam int CNT_W = LEN_W + 3;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NDBPS_W-1:0] sym_q, sym_d;
  logic [NDBPS_W-1:0] ndbps_q, ndbps_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               out_valid_q, out_valid_d;
  logic               out_bit_q, out_bit_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
  logic               serr_q, serr_d;
  logic               rerr_q, rerr_d;
  logic               lfsr_load, lfsr_step, key, descr, sym_wrap;
  logic [CNT_W-1:0]   psdu_bits;

  descrambler_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .bit_i  (in_bit_i),
    .key_o  (key)
  );

  assign descr     = in_bit_i ^ key;
  assign sym_wrap  = (sym_q == ndbps_q - 1'b1);
  assign psdu_bits = {len_q, 3'b000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_d       = sym_q;
    ndbps_d     = ndbps_q;
    len_d       = len_q;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    serr_d      = serr_q;
    rerr_d      = rerr_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    // Start wins over any frame in flight; a bit arriving with it is the first seed bit.
    if (start_i) begin
      serr_d  = 1'b0;
      cnt_d   = '0;
      sym_d   = '0;
      if (ndbps_i < NDBPS_W'(NDBPS_MIN)) begin
        rerr_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        rerr_d  = 1'b0;
        len_d   = length_i;
        ndbps_d = ndbps_i;
        state_d = ST_SEED;
        if (in_valid_i) begin
          lfsr_load = 1'b1;
          cnt_d     = CNT_W'(1);
          sym_d     = NDBPS_W'(1);
        end
      end
    end else if (in_valid_i && state_q != ST_IDLE) begin
      sym_d     = sym_wrap ? '0 : sym_q + 1'b1;
      cnt_d     = cnt_q + 1'b1;
      lfsr_step = 1'b1;
      case (state_q)
        ST_SEED: begin
          lfsr_step = 1'b0;
          lfsr_load = 1'b1;
          if (cnt_q == CNT_W'(SEED_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (descr) serr_d = 1'b1;
          if (cnt_q == CNT_W'(SERVICE_LEN - SEED_LEN - 1)) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? ST_TAIL : ST_PSDU;
          end
        end
        ST_PSDU: begin
          out_valid_d = 1'b1;
          out_bit_d   = descr;
          if (cnt_q == psdu_bits - 1'b1) begin
            out_last_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (cnt_q == CNT_W'(TAIL_LEN - 1)) begin
            cnt_d = '0;
            if (sym_wrap) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (sym_wrap) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sym_q       <= '0;
      ndbps_q     <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      serr_q      <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      ndbps_q     <= ndbps_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      serr_q      <= serr_d;
      rerr_q      <= rerr_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_bit_o     = out_bit_q;
  assign out_last_o    = out_last_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign service_err_o = serr_q;
  assign rate_err_o    = rerr_q;

endmodule

// File: tb/tb_descrambler_frame_ctrl.sv
// tb/tb_descrambler_frame_ctrl.sv - scoreboard bench for descrambler_frame_ctrl
module tb_descrambler_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [11:0] length_i;
  logic [7:0]  ndbps_i;
  logic        in_valid_i;
  logic        in_bit_i;
  logic        out_valid_o, out_bit_o, out_last_o;
  logic        busy_o, done_o, service_err_o, rate_err_o;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  e;
  logic        ks  [0:1023];
  logic        dat [0:1023];

  descrambler_frame_ctrl #(.LEN_W(12), .NDBPS_W(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start_i),
    .length_i      (length_i),
    .ndbps_i       (ndbps_i),
    .in_valid_i    (in_valid_i),
    .in_bit_i      (in_bit_i),
    .out_valid_o   (out_valid_o),
    .out_bit_o     (out_bit_o),
    .out_last_o    (out_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .service_err_o (service_err_o),
    .rate_err_o    (rate_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every presented PSDU bit is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) done_cnt++;
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got bit %0d, expected no output", out_bit_o);
        end else begin
          e = exp_q.pop_front();
          chk("psdu_bit", out_bit_o, e[1]);
          chk("psdu_last", out_last_o, e[0]);
        end
      end else begin
        chk("last_without_valid", out_last_o, 1'b0);
      end
    end
  end

  task automatic drive_bit(input logic b, input logic st);
    start_i    = st;
    in_valid_i = 1'b1;
    in_bit_i   = b;
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
  endtask

  function automatic int total_bits(input int len, input int nd);
    int n;
    n = 22 + 8 * len;
    return ((n + nd - 1) / nd) * nd;
  endfunction

  task automatic fill_dat(input int len, input bit rnd);
    for (int i = 0; i < 1024; i++) dat[i] = 1'b0;
    if (rnd) for (int i = 16; i < 16 + 8 * len; i++) dat[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input int len, input int nd, input bit gaps, input int flip,
                           input logic exp_serr);
    int total, psdu_end, dc0;
    total    = total_bits(len, nd);
    psdu_end = 16 + 8 * len;
    dc0      = done_cnt;
    length_i = len[11:0];
    ndbps_i  = nd[7:0];
    for (int i = 0; i < total; i++) begin
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if (i == total - 1) chk("no_early_done", done_cnt, dc0);
      if (i >= 16 && i < psdu_end) exp_q.push_back({dat[i], 1'(i == psdu_end - 1)});
      drive_bit(dat[i] ^ ks[i] ^ 1'(i == flip), 1'(i == 0));
    end
    @(negedge clk);
    chk("done_pulse", done_o, 1'b1);
    chk("busy_after_frame", busy_o, 1'b0);
    chk("service_err", service_err_o, exp_serr);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dc0;
    for (int i = 0; i < 7; i++) ks[i] = (i >= 4);
    for (int i = 7; i < 1024; i++) ks[i] = ks[i-7] ^ ks[i-4];

    rst = 1'b1; start_i = 1'b0; length_i = '0; ndbps_i = '0;
    in_valid_i = 1'b0; in_bit_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_service_err", service_err_o, 1'b0);
    chk("rst_rate_err", rate_err_o, 1'b0);
    rst = 1'b0;

    // Bits with no Start are ignored.
    repeat (3) drive_bit(1'b1, 1'b0);
    chk("idle_ignores_bits", busy_o, 1'b0);

    fill_dat(1, 1'b0);
    run_frame(1, 24, 1'b0, -1, 1'b0);
    run_frame(1, 24, 1'b0, 10, 1'b1);
    fill_dat(0, 1'b0);
    run_frame(0, 24, 1'b0, -1, 1'b0);
    fill_dat(100, 1'b1);
    run_frame(100, 216, 1'b0, -1, 1'b0);
    run_frame(100, 216, 1'b1, -1, 1'b0);

    // Reset at the third PSDU bit of a frame that already flagged a SERVICE error.
    fill_dat(1, 1'b0);
    length_i = 12'd1; ndbps_i = 8'd24;
    for (int i = 0; i < 19; i++) begin
      if (i >= 16) exp_q.push_back({dat[i], 1'b0});
      drive_bit(dat[i] ^ ks[i] ^ 1'(i == 10), 1'(i == 0));
    end
    chk("pre_reset_valid", out_valid_o, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("reset_out_valid", out_valid_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_service_err", service_err_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(1, 24, 1'b0, -1, 1'b0);

    // Abort a Length=2 frame after four PSDU bits.
    length_i = 12'd2; ndbps_i = 8'd24;
    for (int i = 0; i < 20; i++) begin
      if (i >= 16) exp_q.push_back({dat[i], 1'b0});
      drive_bit(dat[i] ^ ks[i], 1'(i == 0));
    end
    dc0 = done_cnt;
    run_frame(1, 24, 1'b0, -1, 1'b0);
    chk("abort_done_count", done_cnt, dc0 + 1);

    // Refused rate.
    ndbps_i = 8'd12;
    drive_bit(1'b0, 1'b1);
    chk("rate_err_set", rate_err_o, 1'b1);
    chk("rate_err_busy", busy_o, 1'b0);
    repeat (3) drive_bit(1'b1, 1'b0);
    chk("rate_err_stays_idle", busy_o, 1'b0);
    run_frame(1, 24, 1'b0, -1, 1'b0);
    chk("rate_err_cleared", rate_err_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
